// File: rtl/block_xfer_seq.sv
// LDM/STM block-transfer sequencer: walks the register list lowest-first,
// one memory beat per acknowledged request, then reports base writeback.
module block_xfer_seq (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [31:0] insn,
  input  logic [31:0] base,
  input  logic        mem_ack,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] addr,
  output logic [3:0]  reg_num,
  output logic        done,
  output logic        wb_en,
  output logic [31:0] wb_value
);

  typedef enum logic [1:0] {IDLE, XFER, FIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wbv_q, wbv_d;
  logic [4:0]  n_q, n_d;
  logic        l_q, l_d;
  logic        w_q, w_d;

  logic [4:0]  pop;
  logic [31:0] four_n;
  logic [3:0]  low_idx;
  logic        unused_insn;

  assign unused_insn = ^{insn[31:25], insn[22], insn[19:16]};

  always_comb begin
    pop = '0;
    for (int i = 0; i < 16; i++) pop = pop + {4'd0, insn[i]};
  end

  assign four_n = {25'd0, pop, 2'b00};

  // Scan from the top so the last hit is the lowest set bit.
  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) if (rem_q[i]) low_idx = 4'(i);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    wbv_d   = wbv_q;
    n_d     = n_q;
    l_d     = l_q;
    w_d     = w_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d = insn[15:0];
          l_d   = insn[20];
          w_d   = insn[21];
          n_d   = pop;
          // Beats always run at ascending addresses, so descending modes
          // start at the bottom of the block.
          case ({insn[24], insn[23]})
            2'b01:   addr_d = base;
            2'b11:   addr_d = base + 32'd4;
            2'b00:   addr_d = base - four_n + 32'd4;
            default: addr_d = base - four_n;
          endcase
          wbv_d   = insn[23] ? base + four_n : base - four_n;
          state_d = (insn[15:0] != 16'd0) ? XFER : FIN;
        end
      end
      XFER: begin
        if (mem_ack) begin
          rem_d  = rem_q & (rem_q - 16'd1);
          addr_d = addr_q + 32'd4;
          if (rem_d == 16'd0) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      wbv_q   <= '0;
      n_q     <= '0;
      l_q     <= 1'b0;
      w_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      wbv_q   <= wbv_d;
      n_q     <= n_d;
      l_q     <= l_d;
      w_q     <= w_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign mem_req  = (state_q == XFER);
  assign mem_wr   = mem_req & ~l_q;
  assign addr     = addr_q;
  assign reg_num  = low_idx;
  assign done     = (state_q == FIN);
  assign wb_en    = done & w_q & (n_q != 5'd0);
  assign wb_value = wbv_q;

endmodule
